cpu_control_sequencer: RTL and testbench
========================================

CPU_CONTROL_SEQUENCER -- requirements
Module: cpu_control_sequencer

Interface
REQ-001 SHALL have port clk, input, 1, system clock; all state changes occur on its rising edge.
REQ-002 SHALL have port clr, input, 1, asynchronous active-high reset.
REQ-003 SHALL have port run, input, 1, level; permits leaving IDLE and starting each new fetch.
REQ-004 SHALL have port mem_ready, input, 1, memory read data valid on Mdatain.
REQ-005 SHALL have port ir, input, 32, current IR contents; opcode=ir[31:27], Ra=ir[26:23], Rb=ir[22:19], Rc=ir[18:15].
REQ-006 SHALL have ports R_in and R_out, output, 16 each, one-hot-or-zero register enables; bit n drives Rnin/Rnout.
REQ-007 SHALL have 1-bit outputs PCout, MARin, IncPC, MDRread, MDRin, MDRout, IRin, Yin, Zin, ZLowSelect, ZHighSelect, ZLOout, ZHIout, Loin and HIin, each driving the datapath signal of the same name.
REQ-008 SHALL have port ALU_opcode, output, 5, the ALU operation.
REQ-009 SHALL have 1-bit outputs busy, halted, mem_err and illegal.

Function
REQ-010 SHALL implement a Moore state machine with states IDLE, T0, T1, T2, T3, T4, T5, T6 and HALT; all control outputs SHALL decode from the registered state and ir only.
REQ-011 IDLE SHALL assert no controls; it SHALL go to T0 on a clk edge with run=1.
REQ-012 T0 SHALL assert PCout, MARin and IncPC for exactly 1 cycle, then go to T1.
REQ-013 T1 SHALL assert MDRread and MDRin every cycle and stay in T1 until mem_ready=1 at a clk edge, then go to T2.
REQ-014 A 4-bit wait counter SHALL clear on entry to T1 and increment each T1 cycle with mem_ready=0.
- At count 15 with mem_ready=0, the FSM SHALL go to HALT and set mem_err.
REQ-015 T2 SHALL assert MDRout and IRin, then go to T3.
REQ-016 Decode in T3 uses ir opcode classes:
- ALU class: 0-14 and 17-26.
- MULDIV class: 15 and 16.
- NOP: 27.
- HALTOP: 28.
- Illegal: 29-31.
REQ-017 For ALU or MULDIV, T3 SHALL assert R_out[Rb] and Yin.
REQ-018 For NOP, T3 SHALL go to T0 if run=1, else to IDLE.
REQ-019 For HALTOP, T3 SHALL go to HALT.
REQ-020 For an illegal opcode, T3 SHALL pulse illegal for 1 cycle and continue as for NOP.
REQ-021 T4 SHALL assert R_out[Rc] and Zin, and SHALL drive ALU_opcode=ir[31:27].
- ALU_opcode SHALL be 0 in all other states.
REQ-022 For ALU, T5 SHALL assert ZLowSelect, ZLOout and R_in[Ra]; the instruction then ends.
REQ-023 For MULDIV, T5 SHALL assert ZLowSelect, ZLOout and Loin, then go to T6.
REQ-024 T6 SHALL assert ZHighSelect, ZHIout and HIin; the instruction then ends.
REQ-025 At instruction end, the next state SHALL be T0 if run=1, else IDLE.
- run deasserted mid-instruction SHALL NOT abort the instruction.
REQ-026 At most one *out signal SHALL be high in any cycle, and R_in/R_out SHALL never have more than one bit set.
REQ-027 busy SHALL be 1 in T0-T6.
REQ-028 halted SHALL be 1 in HALT.
REQ-029 HALT SHALL assert no datapath controls and SHALL be left only by clr.
REQ-030 mem_err and illegal SHALL be mutually independent flags.
- mem_err SHALL be sticky until clr.
- illegal is a 1-cycle pulse.

Reset
REQ-031 clr=1 SHALL immediately and asynchronously force IDLE, including mid-instruction.
- All outputs go to 0, wait counter goes to 0, mem_err goes to 0.
REQ-032 The FSM SHALL first leave IDLE on the first clk edge after clr falls with run=1.

Verification
REQ-033 Scenario: run=1, mem_ready=1, ir opcode=3, Ra=2, Rb=4, Rc=5.
- Required: T0 → T1 → T2 → T3 (R_out=0x0010) → T4 (R_out=0x0020, ALU_opcode=3) → T5 (R_in=0x0004), then T0.
- Total: 6 cycles.
REQ-034 Scenario: opcode=15.
- Required: T5 asserts Loin, T6 asserts HIin, R_in=0 throughout, 7 cycles total.
REQ-035 Scenario: mem_ready held 0.
- Required: exactly 16 T1 cycles, then HALT with halted=1 and mem_err=1.
- Also: run toggling leaves the FSM in HALT until clr.
REQ-036 Scenario: opcode=30.
- Required: illegal=1 for one cycle in T3, next state T0, no Yin/Zin.
REQ-037 Scenario: clr asserted mid-T4.
- Required: outputs go to 0 immediately, without a clk edge.
- After release with run=0, the FSM stays in IDLE.
REQ-038 Scenario: run dropped during T2 of an ALU instruction.
- Required: the instruction completes through T5, then IDLE, busy=0.

Source files
------------

// File: rtl/cpu_control_sequencer_if.sv
// Bundles the run/memory/IR inputs and every control output of the sequencer.
// The sequencer takes the slave view. The environment driving it takes the master view.
interface cpu_control_sequencer_if;
  logic        run;
  logic        mem_ready;
  logic [31:0] ir;

  logic [15:0] R_in;
  logic [15:0] R_out;
  logic        PCout;
  logic        MARin;
  logic        IncPC;
  logic        MDRread;
  logic        MDRin;
  logic        MDRout;
  logic        IRin;
  logic        Yin;
  logic        Zin;
  logic        ZLowSelect;
  logic        ZHighSelect;
  logic        ZLOout;
  logic        ZHIout;
  logic        Loin;
  logic        HIin;
  logic [4:0]  ALU_opcode;
  logic        busy;
  logic        halted;
  logic        mem_err;
  logic        illegal;

  modport master (
    output run, mem_ready, ir,
    input  R_in, R_out, PCout, MARin, IncPC, MDRread, MDRin, MDRout, IRin,
           Yin, Zin, ZLowSelect, ZHighSelect, ZLOout, ZHIout, Loin, HIin,
           ALU_opcode, busy, halted, mem_err, illegal
  );

  modport slave (
    input  run, mem_ready, ir,
    output R_in, R_out, PCout, MARin, IncPC, MDRread, MDRin, MDRout, IRin,
           Yin, Zin, ZLowSelect, ZHighSelect, ZLOout, ZHIout, Loin, HIin,
           ALU_opcode, busy, halted, mem_err, illegal
  );
endinterface

// File: rtl/cpu_control_sequencer.sv
// Moore control sequencer for a multi-cycle CPU datapath.
// It covers fetch, a memory wait with a timeout, decode and ALU/MULDIV execute.
//
// state | meaning
// IDLE  | no controls, wait for run
// T0    | PC -> MAR, PC increment
// T1    | memory read, wait for mem_ready (max 16 cycles)
// T2    | MDR -> IR
// T3    | decode; Rb -> Y for ALU/MULDIV, flag illegal opcodes
// T4    | Rc -> ALU, result into Z
// T5    | Z low -> Ra (ALU) or LO (MULDIV)
// T6    | Z high -> HI (MULDIV only)
// HALT  | stopped; only clr leaves
module cpu_control_sequencer (
  input  logic                  clk,
  input  logic                  clr,
  cpu_control_sequencer_if.slave bus
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_T0,
    S_T1,
    S_T2,
    S_T3,
    S_T4,
    S_T5,
    S_T6,
    S_HALT
  } state_t;

  typedef enum logic [2:0] {
    C_ALU,
    C_MULDIV,
    C_NOP,
    C_HALTOP,
    C_ILLEGAL
  } opclass_t;

  state_t     state_q, state_d;
  logic [3:0] wait_q,  wait_d;
  logic       mem_err_q, mem_err_d;

  logic [4:0] opcode;
  logic [3:0] ra, rb, rc;
  opclass_t   op_class;

  logic [15:0] r_in_w, r_out_w;
  logic        pc_out_w, mar_in_w, inc_pc_w;
  logic        mdr_read_w, mdr_in_w, mdr_out_w, ir_in_w;
  logic        y_in_w, z_in_w;
  logic        z_low_sel_w, z_high_sel_w, zlo_out_w, zhi_out_w;
  logic        lo_in_w, hi_in_w;
  logic [4:0]  alu_op_w;
  logic        illegal_w;
  logic        run_next_instr;

  function automatic opclass_t classify(input logic [4:0] op);
    if (op == 5'd15 || op == 5'd16) return C_MULDIV;
    if (op <= 5'd26)                return C_ALU;
    if (op == 5'd27)                return C_NOP;
    if (op == 5'd28)                return C_HALTOP;
    return C_ILLEGAL;
  endfunction

  function automatic logic [15:0] dec16(input logic [3:0] idx);
    logic [15:0] one;
    one = 16'h0001;
    return one << idx;
  endfunction

  assign opcode   = bus.ir[31:27];
  assign ra       = bus.ir[26:23];
  assign rb       = bus.ir[22:19];
  assign rc       = bus.ir[18:15];
  assign op_class = classify(opcode);

  logic unused_ir_bits;
  assign unused_ir_bits = ^bus.ir[14:0];

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q   <= S_IDLE;
      wait_q    <= 4'd0;
      mem_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      mem_err_q <= mem_err_d;
    end
  end

  // At every instruction end the sequencer samples run and either fetches again or idles.
  assign run_next_instr = bus.run;

  always_comb begin
    state_d   = state_q;
    wait_d    = wait_q;
    mem_err_d = mem_err_q;
    case (state_q)
      S_IDLE: begin
        if (bus.run) state_d = S_T0;
      end
      S_T0: begin
        state_d = S_T1;
        wait_d  = 4'd0;
      end
      S_T1: begin
        if (bus.mem_ready) begin
          state_d = S_T2;
        end else if (wait_q == 4'd15) begin
          state_d   = S_HALT;
          mem_err_d = 1'b1;
        end else begin
          wait_d = wait_q + 4'd1;
        end
      end
      S_T2: state_d = S_T3;
      S_T3: begin
        case (op_class)
          C_ALU, C_MULDIV: state_d = S_T4;
          C_HALTOP:        state_d = S_HALT;
          default:         state_d = run_next_instr ? S_T0 : S_IDLE;
        endcase
      end
      S_T4: state_d = S_T5;
      S_T5: begin
        if (op_class == C_MULDIV) state_d = S_T6;
        else                      state_d = run_next_instr ? S_T0 : S_IDLE;
      end
      S_T6:    state_d = run_next_instr ? S_T0 : S_IDLE;
      S_HALT:  state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    r_in_w       = 16'h0000;
    r_out_w      = 16'h0000;
    pc_out_w     = 1'b0;
    mar_in_w     = 1'b0;
    inc_pc_w     = 1'b0;
    mdr_read_w   = 1'b0;
    mdr_in_w     = 1'b0;
    mdr_out_w    = 1'b0;
    ir_in_w      = 1'b0;
    y_in_w       = 1'b0;
    z_in_w       = 1'b0;
    z_low_sel_w  = 1'b0;
    z_high_sel_w = 1'b0;
    zlo_out_w    = 1'b0;
    zhi_out_w    = 1'b0;
    lo_in_w      = 1'b0;
    hi_in_w      = 1'b0;
    alu_op_w     = 5'd0;
    illegal_w    = 1'b0;
    case (state_q)
      S_T0: begin
        pc_out_w = 1'b1;
        mar_in_w = 1'b1;
        inc_pc_w = 1'b1;
      end
      S_T1: begin
        mdr_read_w = 1'b1;
        mdr_in_w   = 1'b1;
      end
      S_T2: begin
        mdr_out_w = 1'b1;
        ir_in_w   = 1'b1;
      end
      S_T3: begin
        if (op_class == C_ALU || op_class == C_MULDIV) begin
          r_out_w = dec16(rb);
          y_in_w  = 1'b1;
        end else if (op_class == C_ILLEGAL) begin
          illegal_w = 1'b1;
        end
      end
      S_T4: begin
        r_out_w  = dec16(rc);
        z_in_w   = 1'b1;
        alu_op_w = opcode;
      end
      S_T5: begin
        if (op_class == C_ALU || op_class == C_MULDIV) begin
          z_low_sel_w = 1'b1;
          zlo_out_w   = 1'b1;
          if (op_class == C_ALU) r_in_w  = dec16(ra);
          else                   lo_in_w = 1'b1;
        end
      end
      S_T6: begin
        z_high_sel_w = 1'b1;
        zhi_out_w    = 1'b1;
        hi_in_w      = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.R_in        = r_in_w;
  assign bus.R_out       = r_out_w;
  assign bus.PCout       = pc_out_w;
  assign bus.MARin       = mar_in_w;
  assign bus.IncPC       = inc_pc_w;
  assign bus.MDRread     = mdr_read_w;
  assign bus.MDRin       = mdr_in_w;
  assign bus.MDRout      = mdr_out_w;
  assign bus.IRin        = ir_in_w;
  assign bus.Yin         = y_in_w;
  assign bus.Zin         = z_in_w;
  assign bus.ZLowSelect  = z_low_sel_w;
  assign bus.ZHighSelect = z_high_sel_w;
  assign bus.ZLOout      = zlo_out_w;
  assign bus.ZHIout      = zhi_out_w;
  assign bus.Loin        = lo_in_w;
  assign bus.HIin        = hi_in_w;
  assign bus.ALU_opcode  = alu_op_w;
  assign bus.busy        = (state_q != S_IDLE) && (state_q != S_HALT);
  assign bus.halted      = (state_q == S_HALT);
  assign bus.mem_err     = mem_err_q;
  assign bus.illegal     = illegal_w;

  // Only one source may drive the shared bus in any cycle.
  a_rin_onehot: assert property (@(posedge clk) disable iff (clr) $onehot0(r_in_w));
  a_rout_onehot: assert property (@(posedge clk) disable iff (clr) $onehot0(r_out_w));
  a_single_out: assert property (@(posedge clk) disable iff (clr)
    $onehot0({pc_out_w, mdr_out_w, zlo_out_w, zhi_out_w, (r_out_w != 16'h0000)}));

endmodule

// File: tb/tb_cpu_control_sequencer.sv
// Randomized scoreboard bench for cpu_control_sequencer.
// A phase-list model predicts every cycle's control word, and a monitor compares it on the falling edge.
module tb_cpu_control_sequencer;

  logic clk = 1'b0;
  logic clr;
  always #5 clk = ~clk;

  cpu_control_sequencer_if bus();

  cpu_control_sequencer dut (
    .clk (clk),
    .clr (clr),
    .bus (bus.slave)
  );

  typedef struct packed {
    logic [15:0] r_in;
    logic [15:0] r_out;
    logic pcout, marin, incpc, mdrread, mdrin, mdrout, irin, yin, zin;
    logic zlows, zhighs, zloout, zhiout, loin, hiin;
    logic [4:0] alu;
    logic busy, halted, mem_err, illegal;
  } cw_t;

  typedef struct {
    cw_t cw;
    int  ph;
  } exp_t;

  localparam int PH_IDLE = 0, PH_T0 = 1, PH_T1 = 2, PH_T2 = 3, PH_T3 = 4,
                 PH_T4 = 5, PH_T5 = 6, PH_T6 = 7, PH_HALT = 8;

  exp_t sb_q[$];
  int   n_vec = 0;
  int   n_err = 0;
  logic exp_mem_err = 1'b0;
  int   mode = 1;  // 0: DUT in T0 now, 1: in IDLE, 2: in HALT

  function automatic cw_t phase_cw(input int ph, input logic [31:0] ir, input logic merr);
    cw_t c;
    logic [4:0] op;
    bit md, alu;
    c   = '0;
    op  = ir[31:27];
    md  = (op == 5'd15) || (op == 5'd16);
    alu = (op < 5'd27) && !md;
    c.mem_err = merr;
    c.busy    = (ph >= PH_T0) && (ph <= PH_T6);
    case (ph)
      PH_T0: begin c.pcout = 1'b1; c.marin = 1'b1; c.incpc = 1'b1; end
      PH_T1: begin c.mdrread = 1'b1; c.mdrin = 1'b1; end
      PH_T2: begin c.mdrout = 1'b1; c.irin = 1'b1; end
      PH_T3: begin
        if (alu || md) begin c.r_out[ir[22:19]] = 1'b1; c.yin = 1'b1; end
        c.illegal = (op > 5'd28);
      end
      PH_T4: begin c.r_out[ir[18:15]] = 1'b1; c.zin = 1'b1; c.alu = op; end
      PH_T5: begin
        c.zlows = 1'b1; c.zloout = 1'b1;
        if (alu) c.r_in[ir[26:23]] = 1'b1;
        else     c.loin = 1'b1;
      end
      PH_T6: begin c.zhighs = 1'b1; c.zhiout = 1'b1; c.hiin = 1'b1; end
      PH_HALT: c.halted = 1'b1;
      default: ;
    endcase
    return c;
  endfunction

  function automatic cw_t sample();
    cw_t c;
    c.r_in = bus.R_in;       c.r_out = bus.R_out;
    c.pcout = bus.PCout;     c.marin = bus.MARin;    c.incpc = bus.IncPC;
    c.mdrread = bus.MDRread; c.mdrin = bus.MDRin;    c.mdrout = bus.MDRout;
    c.irin = bus.IRin;       c.yin = bus.Yin;        c.zin = bus.Zin;
    c.zlows = bus.ZLowSelect; c.zhighs = bus.ZHighSelect;
    c.zloout = bus.ZLOout;   c.zhiout = bus.ZHIout;
    c.loin = bus.Loin;       c.hiin = bus.HIin;      c.alu = bus.ALU_opcode;
    c.busy = bus.busy;       c.halted = bus.halted;
    c.mem_err = bus.mem_err; c.illegal = bus.illegal;
    return c;
  endfunction

  task automatic push_exp(input int ph, input logic [31:0] ir);
    exp_t e;
    e.cw = phase_cw(ph, ir, exp_mem_err);
    e.ph = ph;
    sb_q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (!clr && sb_q.size() > 0) begin
      exp_t e;
      cw_t  a;
      int   outs;
      e = sb_q.pop_front();
      a = sample();
      n_vec++;
      if (a !== e.cw) begin
        n_err++;
        $display("FAIL cycle phase=%0d t=%0t actual=%h expected=%h", e.ph, $time, a, e.cw);
      end
      outs = $countones({a.pcout, a.mdrout, a.zloout, a.zhiout, (a.r_out != 16'h0)});
      n_vec++;
      if (!($onehot0(a.r_in) && $onehot0(a.r_out) && outs <= 1)) begin
        n_err++;
        $display("FAIL exclusivity t=%0t actual R_in=%h R_out=%h outs=%0d required onehot0/<=1",
                 $time, a.r_in, a.r_out, outs);
      end
    end
  end

  task automatic check_zero(input string nm);
    cw_t a;
    a = sample();
    n_vec++;
    if (a !== '0) begin
      n_err++;
      $display("FAIL %s t=%0t actual=%h required=0", nm, $time, a);
    end
  endtask

  // Asserts clr between clock edges and checks the outputs without any edge.
  task automatic do_clr(input bit rel_run);
    @(negedge clk);
    #1 clr = 1'b1;
    #1 check_zero("clr_async");
    bus.run = rel_run;
    bus.mem_ready = 1'($urandom);
    #1 check_zero("clr_hold");
    #1 clr = 1'b0;
    exp_mem_err = 1'b0;
    @(posedge clk);
    #1 mode = rel_run ? 0 : 1;
  endtask

  task automatic go_to_t0(input int n_idle);
    for (int i = 0; i < n_idle; i++) begin
      push_exp(PH_IDLE, bus.ir);
      bus.run = 1'b0;
      bus.mem_ready = 1'($urandom);
      @(posedge clk);
      #1;
    end
    push_exp(PH_IDLE, bus.ir);
    bus.run = 1'b1;
    @(posedge clk);
    #1 mode = 0;
  endtask

  task automatic handle_halt();
    for (int i = 0; i < 5; i++) begin
      push_exp(PH_HALT, bus.ir);
      bus.run = 1'($urandom);
      bus.mem_ready = 1'($urandom);
      if (i < 4) begin
        @(posedge clk);
        #1;
      end
    end
    do_clr(1'($urandom));
  endtask

  task automatic settle(input int n_idle);
    if (mode == 2) handle_halt();
    if (mode == 1) go_to_t0(n_idle);
  endtask

  // Call this in a T0 cycle. The model's phase list is pushed at once, and then the inputs are driven cycle by cycle.
  task automatic do_instr(input logic [31:0] ir, input int lat, input int drop_idx,
                          input int clr_at, input bit clr_run);
    int ph[$];
    bit mr[$];
    bit rn[$];
    bit halts;
    logic [4:0] op;
    int t1n, n;
    op = ir[31:27];
    halts = 1'b0;
    bus.ir = ir;
    ph.push_back(PH_T0); mr.push_back(1'($urandom));
    t1n = (lat >= 16) ? 16 : lat + 1;
    for (int k = 0; k < t1n; k++) begin
      ph.push_back(PH_T1);
      mr.push_back(k == lat);
    end
    if (lat >= 16) begin
      halts = 1'b1;
    end else begin
      ph.push_back(PH_T2); mr.push_back(1'($urandom));
      ph.push_back(PH_T3); mr.push_back(1'($urandom));
      if (op == 5'd28) begin
        halts = 1'b1;
      end else if (op < 5'd27) begin
        ph.push_back(PH_T4); mr.push_back(1'($urandom));
        ph.push_back(PH_T5); mr.push_back(1'($urandom));
        if (op == 5'd15 || op == 5'd16) begin
          ph.push_back(PH_T6); mr.push_back(1'($urandom));
        end
      end
    end
    n = ph.size();
    for (int j = 0; j < n; j++) rn.push_back(!(drop_idx >= 0 && j >= drop_idx));
    for (int j = 0; j < n; j++)
      if (clr_at < 0 || j <= clr_at) push_exp(ph[j], ir);
    for (int j = 0; j < n; j++) begin
      bus.mem_ready = mr[j];
      bus.run = rn[j];
      if (j == clr_at) begin
        do_clr(clr_run);
        return;
      end
      @(posedge clk);
      #1;
    end
    if (halts) begin
      mode = 2;
      if (lat >= 16) exp_mem_err = 1'b1;
    end else begin
      mode = rn[n-1] ? 0 : 1;
    end
  endtask

  function automatic logic [31:0] mk_ir(input logic [4:0] op);
    return {op, 27'($urandom)};
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: run did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4:0] op;
    int r, lat, drop, cat;
    clr = 1'b1;
    bus.run = 1'b0;
    bus.mem_ready = 1'b0;
    bus.ir = 32'h0;
    @(negedge clk);
    #1 check_zero("reset");
    #2 clr = 1'b0;
    @(posedge clk);
    #1 mode = 1;

    go_to_t0(2);
    do_instr({5'd3, 4'd2, 4'd4, 4'd5, 15'd0}, 0, -1, -1, 1'b0);
    settle(1);
    do_instr(mk_ir(5'd15), 0, -1, -1, 1'b0);
    settle(1);
    do_instr(mk_ir(5'd30), 0, -1, -1, 1'b0);
    settle(1);
    do_instr(mk_ir(5'd7), 2, 4, -1, 1'b0);
    settle(3);
    do_instr(mk_ir(5'd9), 0, -1, 4, 1'b0);
    settle(4);
    do_instr(mk_ir(5'd1), 15, -1, -1, 1'b0);
    settle(1);
    do_instr(mk_ir(5'd2), 16, -1, -1, 1'b0);
    settle(2);
    do_instr(mk_ir(5'd28), 0, -1, -1, 1'b0);
    settle(1);

    for (int i = 0; i < 150; i++) begin
      op = 5'($urandom_range(0, 31));
      if (op == 5'd28 && $urandom_range(0, 3) != 0) op = 5'd27;
      r = $urandom_range(0, 19);
      if (r < 12)       lat = r % 4;
      else if (r < 19)  lat = $urandom_range(4, 15);
      else              lat = 16;
      drop = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 12) : -1;
      cat  = ($urandom_range(0, 24) == 0) ? $urandom_range(0, 3) : -1;
      do_instr(mk_ir(op), lat, drop, cat, 1'($urandom));
      settle($urandom_range(0, 2));
    end

    @(negedge clk);
    #1;
    n_vec++;
    if (sb_q.size() != 0) begin
      n_err++;
      $display("FAIL drain actual=%0d pending required=0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
